// File: rtl/sys_pkg.sv
// Shared types and arithmetic helpers for the weight-stationary systolic column.
package sys_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam int unsigned SAT_ADD_W = 64;

    // Signed add of two sign-extended operands; clamps to a w-bit signed range when sat is set,
    // otherwise the caller's truncation to w bits provides the modular wrap.
    function automatic logic signed [SAT_ADD_W-1:0] sat_add(
        input logic signed [SAT_ADD_W-1:0] a,
        input logic signed [SAT_ADD_W-1:0] b,
        input int unsigned                 w,
        input logic                        sat
    );
        logic signed [SAT_ADD_W:0] s;
        logic signed [SAT_ADD_W:0] hi;
        logic signed [SAT_ADD_W:0] lo;
        s  = (SAT_ADD_W+1)'(a) + (SAT_ADD_W+1)'(b);
        hi = ((SAT_ADD_W+1)'(1) <<< (w - 1)) - (SAT_ADD_W+1)'(1);
        lo = -((SAT_ADD_W+1)'(1) <<< (w - 1));
        if (sat && (s > hi)) begin
            return hi[SAT_ADD_W-1:0];
        end
        if (sat && (s < lo)) begin
            return lo[SAT_ADD_W-1:0];
        end
        return s[SAT_ADD_W-1:0];
    endfunction

endpackage

// File: rtl/sys_pe_ws.sv
// One weight-stationary PE: shiftable weight register, MAC stage and travelling valid bit.
module sys_pe_ws #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter bit          SAT       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_shift,
    input  logic [WIDTH-1:0]     w_in,
    output logic [WIDTH-1:0]     w_out,
    input  logic [WIDTH-1:0]     x_in,
    input  logic                 v_in,
    input  logic [ACC_WIDTH-1:0] p_in,
    output logic                 v_out,
    output logic [ACC_WIDTH-1:0] p_out
);
    import sys_pkg::*;

    logic [WIDTH-1:0]          w_q;
    logic signed [2*WIDTH-1:0] prod;

    assign prod  = (2*WIDTH)'($signed(w_q)) * (2*WIDTH)'($signed(x_in));
    assign w_out = w_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else if (w_shift) begin
            w_q <= w_in;
        end
    end

    // Bubbles advance the valid bit but leave the held partial sum untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out <= 1'b0;
            p_out <= '0;
        end else begin
            v_out <= v_in;
            if (v_in) begin
                p_out <= ACC_WIDTH'(sat_add(SAT_ADD_W'($signed(p_in)), SAT_ADD_W'(prod),
                                            ACC_WIDTH, SAT));
            end
        end
    end

endmodule

// File: rtl/sys_vector_ws.sv
// Weight-stationary systolic column: load/run/drain control, input skew and the PE cascade.
module sys_vector_ws #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned ROWS      = 32,
    parameter bit          SAT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  w_valid,
    input  logic [WIDTH-1:0]      w_data,
    output logic                  w_ready,
    input  logic                  f_valid,
    input  logic [ROWS*WIDTH-1:0] f_data,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    output logic                  f_ready,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  busy
);
    import sys_pkg::*;

    localparam int unsigned CNT_W = $clog2(ROWS);
    localparam int unsigned INF_W = $clog2(ROWS + 1);

    state_t               state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [INF_W-1:0]     inflight;
    logic                 f_accept;
    logic                 w_accept;

    logic [WIDTH-1:0]     w_chain [ROWS];
    logic [ACC_WIDTH-1:0] p_chain [ROWS];
    logic                 v_chain [ROWS];

    // Refuse a beat in the very cycle a reload is requested.
    assign f_ready  = (state == RUN) && !load_start;
    assign f_accept = f_valid && f_ready;
    assign w_accept = w_valid && w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            w_ready  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= LOAD;
                        beat_cnt <= '0;
                        w_ready  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        beat_cnt <= '0;
                    end else if (w_accept) begin
                        if (beat_cnt == CNT_W'(ROWS - 1)) begin
                            state    <= RUN;
                            beat_cnt <= '0;
                            w_ready  <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (load_start) begin
                        state <= DRAIN;
                        busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (inflight == '0) begin
                        state    <= LOAD;
                        beat_cnt <= '0;
                        w_ready  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    w_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Counts down the cycles until the newest accepted token has left the column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (f_accept) begin
            inflight <= INF_W'(ROWS);
        end else if (inflight != '0) begin
            inflight <= inflight - INF_W'(1);
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        logic [WIDTH-1:0]     x_row;
        logic [WIDTH-1:0]     w_prev;
        logic [ACC_WIDTH-1:0] p_prev;
        logic                 v_prev;

        if (i == 0) begin : g_head
            assign x_row  = f_data[WIDTH-1:0];
            assign w_prev = w_data;
            assign p_prev = psum_in;
            assign v_prev = f_accept;
        end else begin : g_body
            logic [WIDTH-1:0] dly [i];

            // Row i sees its feature i cycles late, lining it up with the cascading partial sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        dly[k] <= '0;
                    end
                end else begin
                    dly[0] <= f_data[i*WIDTH +: WIDTH];
                    for (int k = 1; k < i; k++) begin
                        dly[k] <= dly[k-1];
                    end
                end
            end

            assign x_row  = dly[i-1];
            assign w_prev = w_chain[i-1];
            assign p_prev = p_chain[i-1];
            assign v_prev = v_chain[i-1];
        end

        sys_pe_ws #(
            .WIDTH     (WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SAT       (SAT)
        ) u_pe (
            .clk     (clk),
            .rst     (rst),
            .w_shift (w_accept),
            .w_in    (w_prev),
            .w_out   (w_chain[i]),
            .x_in    (x_row),
            .v_in    (v_prev),
            .p_in    (p_prev),
            .v_out   (v_chain[i]),
            .p_out   (p_chain[i])
        );
    end

    assign out_valid = v_chain[ROWS-1];
    assign psum_out  = p_chain[ROWS-1];

endmodule

// File: tb/tb_sys_vector_ws.sv
// Bench for sys_vector_ws: directed scenarios plus random traffic against a column-sum model.
module tb_sys_vector_ws;

    localparam int unsigned W  = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned A  = 20;
    localparam int unsigned AS = 16;
    localparam logic [63:0] MASK_A  = (64'd1 << A) - 64'd1;
    localparam logic [63:0] MASK_AS = (64'd1 << AS) - 64'd1;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DRAIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, load_start, w_valid, f_valid;
    logic [W-1:0]    w_data;
    logic [R*W-1:0]  f_data;
    logic [A-1:0]    psum_in;
    logic [AS-1:0]   psum_in_s, psum_in_w;
    logic            w_ready, f_ready, out_valid, busy;
    logic [A-1:0]    psum_out;
    logic            w_ready_s, f_ready_s, out_valid_s, busy_s;
    logic [AS-1:0]   psum_out_s;
    logic            w_ready_w, f_ready_w, out_valid_w, busy_w;
    logic [AS-1:0]   psum_out_w;

    sys_vector_ws #(.WIDTH(W), .ACC_WIDTH(A), .ROWS(R), .SAT(1'b0)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .f_valid(f_valid), .f_data(f_data), .psum_in(psum_in),
        .f_ready(f_ready), .out_valid(out_valid), .psum_out(psum_out), .busy(busy));

    sys_vector_ws #(.WIDTH(W), .ACC_WIDTH(AS), .ROWS(R), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .load_start(load_start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready_s), .f_valid(f_valid), .f_data(f_data), .psum_in(psum_in_s),
        .f_ready(f_ready_s), .out_valid(out_valid_s), .psum_out(psum_out_s), .busy(busy_s));

    sys_vector_ws #(.WIDTH(W), .ACC_WIDTH(AS), .ROWS(R), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .load_start(load_start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready_w), .f_valid(f_valid), .f_data(f_data), .psum_in(psum_in_w),
        .f_ready(f_ready_w), .out_valid(out_valid_w), .psum_out(psum_out_w), .busy(busy_w));

    typedef struct {
        int     due;
        longint v;
        longint vs;
        longint vw;
    } exp_t;

    int     n_vec = 0;
    int     n_err = 0;
    int     edges = 0;
    int     mstate, mcnt, minfl;
    longint mw [R];
    exp_t   eq [$];
    longint last, last_s, last_w;
    longint obs_q [$];
    int     drain_cycles;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Fold a running sum into an accw-bit signed range, by clamping or by wrapping.
    function automatic longint fold(input longint v, input int accw, input bit sat);
        longint m, hi, lo, r;
        m  = longint'(1) <<< accw;
        hi = (m >>> 1) - 1;
        lo = -(m >>> 1);
        if (sat) return (v > hi) ? hi : ((v < lo) ? lo : v);
        r = v % m;
        if (r > hi) r -= m;
        if (r < lo) r += m;
        return r;
    endfunction

    function automatic longint col_sum(input longint bias, input logic [R*W-1:0] f,
                                       input int accw, input bit sat);
        longint acc;
        acc = bias;
        for (int r = 0; r < R; r++) begin
            acc = fold(acc + mw[r] * longint'($signed(f[r*W +: W])), accw, sat);
        end
        return acc;
    endfunction

    task automatic model_reset();
        mstate = S_IDLE; mcnt = 0; minfl = 0;
        for (int r = 0; r < R; r++) mw[r] = 0;
        eq.delete();
        last = 0; last_s = 0; last_w = 0;
    endtask

    // One clock: check handshake outputs, advance the model, then check the column outputs.
    task automatic step();
        bit   acc_f, acc_w, exp_v;
        exp_t e;
        #1;
        check_eq("w_ready", 64'(w_ready), 64'(mstate == S_LOAD));
        check_eq("f_ready", 64'(f_ready), 64'(mstate == S_RUN && !load_start));
        check_eq("busy", 64'(busy), 64'(mstate == S_LOAD || mstate == S_DRAIN));
        acc_f = f_valid && mstate == S_RUN && !load_start;
        acc_w = w_valid && mstate == S_LOAD;
        if (acc_f) begin
            e.due = edges + R;
            e.v   = col_sum(longint'($signed(psum_in)), f_data, A, 1'b0);
            e.vs  = col_sum(longint'($signed(psum_in_s)), f_data, AS, 1'b1);
            e.vw  = col_sum(longint'($signed(psum_in_w)), f_data, AS, 1'b0);
            eq.push_back(e);
        end
        if (acc_w) begin
            for (int r = R - 1; r > 0; r--) mw[r] = mw[r-1];
            mw[0] = longint'($signed(w_data));
        end
        case (mstate)
            S_IDLE:  if (load_start) begin mstate = S_LOAD; mcnt = 0; end
            S_LOAD:  if (load_start) mcnt = 0;
                     else if (w_valid) begin
                         if (mcnt == R - 1) begin mstate = S_RUN; mcnt = 0; end
                         else mcnt++;
                     end
            S_RUN:   if (load_start) mstate = S_DRAIN;
            default: if (minfl == 0) begin mstate = S_LOAD; mcnt = 0; end
        endcase
        if (acc_f) minfl = R;
        else if (minfl > 0) minfl--;
        @(posedge clk);
        @(negedge clk);
        edges++;
        exp_v = (eq.size() > 0) && (eq[0].due == edges);
        if (exp_v) begin
            e = eq.pop_front();
            last = e.v; last_s = e.vs; last_w = e.vw;
        end
        check_eq("out_valid", 64'(out_valid), 64'(exp_v));
        check_eq("out_valid_s", 64'(out_valid_s), 64'(exp_v));
        check_eq("out_valid_w", 64'(out_valid_w), 64'(exp_v));
        check_eq("psum_out", 64'(psum_out), 64'(last) & MASK_A);
        check_eq("psum_out_s", 64'(psum_out_s), 64'(last_s) & MASK_AS);
        check_eq("psum_out_w", 64'(psum_out_w), 64'(last_w) & MASK_AS);
        if (out_valid) obs_q.push_back(longint'($signed(psum_out)));
    endtask

    task automatic idle_in();
        load_start = 1'b0; w_valid = 1'b0; f_valid = 1'b0;
        psum_in = '0; psum_in_s = '0; psum_in_w = '0;
    endtask

    task automatic load_beat(input logic [W-1:0] d);
        w_valid = 1'b1; w_data = d;
        step();
        w_valid = 1'b0;
    endtask

    task automatic feature(input logic [R*W-1:0] f, input logic [A-1:0] b);
        f_valid = 1'b1; f_data = f; psum_in = b;
        step();
        f_valid = 1'b0; psum_in = '0;
    endtask

    initial begin
        idle_in();
        w_data = '0; f_data = '0;
        rst = 1'b1;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_psum_out", 64'(psum_out), 64'd0);
        check_eq("rst_w_ready", 64'(w_ready), 64'd0);
        check_eq("rst_f_ready", 64'(f_ready), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // IDLE ignores features
        obs_q.delete();
        f_valid = 1'b1; f_data = 32'h01020304;
        repeat (5) step();
        f_valid = 1'b0;
        check_eq("idle_no_out", 64'(obs_q.size()), 64'd0);

        // partial load then hold with no beats
        load_start = 1'b1; step(); load_start = 1'b0;
        load_beat(8'd9); load_beat(8'd9);
        repeat (3) step();
        check_eq("load_hold", 64'(w_ready), 64'd1);

        // restart the count, load rows 3..0 = 4,3,2,1 with a gap
        load_start = 1'b1; step(); load_start = 1'b0;
        load_beat(8'd4); load_beat(8'd3); step(); load_beat(8'd2); load_beat(8'd1);
        check_eq("run_f_ready", 64'(f_ready), 64'd1);

        obs_q.delete();
        feature(32'h01010101, 20'd5);
        repeat (R - 1) step();
        check_eq("single_valid", 64'(out_valid), 64'd1);
        check_eq("single_15", 64'(psum_out), 64'd15);

        // streaming with a bubble
        obs_q.delete();
        feature(32'h00000001, '0);
        feature(32'h02000000, '0);
        step();
        feature(32'hFFFFFFFF, '0);
        repeat (R + 1) step();
        check_eq("stream_cnt", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() == 3) begin
            check_eq("stream_0", 64'(obs_q[0]), 64'd1);
            check_eq("stream_1", 64'(obs_q[1]), 64'd8);
            check_eq("stream_2", 64'(obs_q[2]), 64'(-64'sd10));
        end

        // reload requested the cycle after an accepted beat
        obs_q.delete();
        feature(32'h05040302, 20'd7);
        load_start = 1'b1; step(); load_start = 1'b0;
        drain_cycles = 0;
        for (int i = 0; i < 20 && !w_ready; i++) begin
            if (busy) drain_cycles++;
            step();
        end
        check_eq("drain_cycles", 64'(drain_cycles), 64'd4);
        check_eq("drain_reached_load", 64'(w_ready), 64'd1);
        check_eq("drain_pending_out", 64'(obs_q.size()), 64'd1);

        // saturation versus wrap on the 16-bit columns
        repeat (R) load_beat(8'd127);
        feature(32'h7F7F7F7F, '0);
        repeat (R - 1) step();
        check_eq("sat_clamp", 64'(psum_out_s), 64'h7FFF);
        check_eq("sat_wrap", 64'(psum_out_w), 64'hFC04);
        check_eq("sat_wide", 64'(psum_out), 64'd64516);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            load_start = ($urandom_range(0, 99) < 3);
            w_valid    = ($urandom_range(0, 99) < 70);
            w_data     = W'($urandom);
            f_valid    = ($urandom_range(0, 99) < 70);
            f_data     = $urandom;
            psum_in    = A'($urandom);
            psum_in_s  = AS'($urandom);
            psum_in_w  = AS'($urandom);
            step();
        end
        idle_in();

        // reach RUN and put three tokens in flight, then reset
        for (int i = 0; i < 60 && mstate != S_RUN; i++) begin
            load_start = (mstate == S_IDLE || mstate == S_RUN);
            w_valid = 1'b1; w_data = W'($urandom);
            step();
        end
        idle_in();
        check_eq("pre_rst_run", 64'(f_ready), 64'd1);
        repeat (3) feature($urandom, A'($urandom));
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_psum_out", 64'(psum_out), 64'd0);
        check_eq("arst_psum_out_s", 64'(psum_out_s), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_f_ready", 64'(f_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        f_valid = 1'b1;
        repeat (8) step();
        f_valid = 1'b0;
        check_eq("post_rst_quiet", 64'(obs_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
